// File: rtl/cv_bus_pkg.sv
// Shared types and helpers for the cv bus producer/consumer cells.
package cv_bus_pkg;

  localparam int CV_BUS_MAX_NBITS = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } cv_bus_state_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cv_bus_drive.sv
// Driving end of the cv bus: deserializes a serial bit stream into NBITS-wide
// words and offers each one with a valid/ready handshake.
module cv_bus_drive
  import cv_bus_pkg::*;
#(
  parameter int NBITS     = 2,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             VDD,
  input  logic             VSS,
  input  logic             sync,
  input  logic             in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [NBITS-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int CW = clog2(NBITS + 1);
  localparam int IW = clog2(NBITS);

  if (NBITS < 2 || NBITS > CV_BUS_MAX_NBITS) begin : g_bad_nbits
    $error("cv_bus_drive: NBITS out of range 2..16");
  end

  // Supply pins exist only so the cell drops into the schematic netlist.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  cv_bus_state_e    state, state_next;
  logic [CW-1:0]    cnt, cnt_next;
  logic [NBITS-1:0] shreg, shreg_next, out_next;
  logic             ovf_next;
  logic [IW-1:0]    wr_idx;

  function automatic logic [IW-1:0] bit_index(input logic [CW-1:0] c);
    if (MSB_FIRST) return IW'(NBITS - 1 - int'(c));
    else           return IW'(int'(c));
  endfunction

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; a missing default here is how latches get inferred.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shreg_next = shreg;
    out_next   = out;
    ovf_next   = ovf;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    wr_idx     = bit_index(cnt);

    unique case (state)
      FILL: begin
        if (in_valid && !sync) begin
          shreg_next[wr_idx] = in;
          if (cnt == CW'(NBITS - 1)) begin
            out_next   = shreg_next;
            shreg_next = '0;
            cnt_next   = '0;
            state_next = HOLD;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        // One-bit skid: a bit is taken only in the cycle the word leaves.
        in_ready  = out_ready;
        if (!sync) begin
          if (out_ready) begin
            state_next = FILL;
            cnt_next   = '0;
            if (in_valid) begin
              shreg_next                 = '0;
              shreg_next[bit_index('0)]  = in;
              cnt_next                   = CW'(1);
            end
          end else if (in_valid) begin
            ovf_next = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Resync wins over everything; a held word is dropped unless consumed now.
    if (sync) begin
      state_next = FILL;
      cnt_next   = '0;
      shreg_next = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      shreg <= '0;
      out   <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      shreg <= shreg_next;
      out   <= out_next;
      ovf   <= ovf_next;
    end
  end

endmodule

// File: tb/tb_cv_bus_drive.sv
// Scoreboard bench for cv_bus_drive: three configurations driven with directed
// bit sequences; a negedge monitor pops expected words on each handshake.
module tb_cv_bus_drive;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vdd = 1'b1;
  logic       vss = 1'b0;
  logic [2:0] in_s   = '0;
  logic [2:0] vld_s  = '0;
  logic [2:0] sync_s = '0;
  logic [2:0] ordy_s = '1;
  logic [2:0] in_ready_s, out_valid_s, ovf_s;
  logic [1:0] out_a, out_b;
  logic [3:0] out_c;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  logic [3:0] q2[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cv_bus_drive #(.NBITS(2), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss), .sync(sync_s[0]),
    .in(in_s[0]), .in_valid(vld_s[0]), .in_ready(in_ready_s[0]),
    .out(out_a), .out_valid(out_valid_s[0]), .out_ready(ordy_s[0]), .ovf(ovf_s[0])
  );

  cv_bus_drive #(.NBITS(2), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss), .sync(sync_s[1]),
    .in(in_s[1]), .in_valid(vld_s[1]), .in_ready(in_ready_s[1]),
    .out(out_b), .out_valid(out_valid_s[1]), .out_ready(ordy_s[1]), .ovf(ovf_s[1])
  );

  cv_bus_drive #(.NBITS(4), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst(rst), .VDD(vdd), .VSS(vss), .sync(sync_s[2]),
    .in(in_s[2]), .in_valid(vld_s[2]), .in_ready(in_ready_s[2]),
    .out(out_c), .out_valid(out_valid_s[2]), .out_ready(ordy_s[2]), .ovf(ovf_s[2])
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic flag_extra(input string name, input logic [31:0] got);
    n_tests++;
    n_fail++;
    $display("FAIL %s: unexpected word %0h with nothing expected", name, got);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drive(input int k, input logic b);
    in_s[k]  = b;
    vld_s[k] = 1'b1;
    cyc();
  endtask

  // Monitor: a word is transferred at the next rising edge when valid and
  // ready are both high midway through the cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid_s[0] && ordy_s[0]) begin
        if (q0.size() == 0) flag_extra("sb_a", 32'(out_a));
        else check("sb_a_word", 32'(out_a), 32'(q0.pop_front()));
      end
      if (out_valid_s[1] && ordy_s[1]) begin
        if (q1.size() == 0) flag_extra("sb_b", 32'(out_b));
        else check("sb_b_word", 32'(out_b), 32'(q1.pop_front()));
      end
      if (out_valid_s[2] && ordy_s[2]) begin
        if (q2.size() == 0) flag_extra("sb_c", 32'(out_c));
        else check("sb_c_word", 32'(out_c), 32'(q2.pop_front()));
      end
    end
  end

  initial begin
    int b4[8];
    b4 = '{1, 0, 1, 1, 0, 0, 1, 0};

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready_s), 32'h7);
    check("rst_out_valid", 32'(out_valid_s), 32'h0);
    check("rst_ovf", 32'(ovf_s), 32'h0);
    check("rst_out_a", 32'(out_a), 32'h0);
    check("rst_out_c", 32'(out_c), 32'h0);
    #9 rst = 1'b0;
    cyc();

    // LSB-first word, out_valid one-cycle pulse
    q0.push_back(4'b0001);
    drive(0, 1'b1);
    drive(0, 1'b0);
    vld_s[0] = 1'b0;
    check("t1_valid", 32'(out_valid_s[0]), 32'h1);
    check("t1_out", 32'(out_a), 32'h1);
    cyc();
    check("t1_pulse", 32'(out_valid_s[0]), 32'h0);
    check("t1_hold", 32'(out_a), 32'h1);

    // Resync discards partial word and ignores the bit on the sync cycle
    q0.push_back(4'b0010);
    drive(0, 1'b1);
    sync_s[0] = 1'b1;
    in_s[0]   = 1'b1;
    vld_s[0]  = 1'b1;
    cyc();
    sync_s[0] = 1'b0;
    check("t5_in_ready", 32'(in_ready_s[0]), 32'h1);
    check("t5_no_valid", 32'(out_valid_s[0]), 32'h0);
    drive(0, 1'b0);
    drive(0, 1'b1);
    vld_s[0] = 1'b0;
    check("t5_out", 32'(out_a), 32'h2);
    cyc();
    check("t5_ovf", 32'(ovf_s[0]), 32'h0);

    // Backpressure with bits offered while held
    ordy_s[0] = 1'b0;
    q0.push_back(4'b0011);
    drive(0, 1'b1);
    drive(0, 1'b1);
    in_s[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t3_in_ready", 32'(in_ready_s[0]), 32'h0);
      check("t3_out_stable", 32'(out_a), 32'h3);
      cyc();
      check("t3_ovf", 32'(ovf_s[0]), 32'h1);
    end
    ordy_s[0] = 1'b1;
    in_s[0]   = 1'b1;
    q0.push_back(4'b0001);
    cyc();
    check("t3_consumed", 32'(out_valid_s[0]), 32'h0);
    drive(0, 1'b0);
    vld_s[0] = 1'b0;
    check("t3_next_word", 32'(out_a), 32'h1);
    cyc();
    check("t3_ovf_sticky", 32'(ovf_s[0]), 32'h1);

    // MSB-first words, then sync while held discards the word
    q1.push_back(4'b0010);
    drive(1, 1'b1);
    drive(1, 1'b0);
    vld_s[1] = 1'b0;
    cyc();
    q1.push_back(4'b0001);
    drive(1, 1'b0);
    drive(1, 1'b1);
    vld_s[1] = 1'b0;
    cyc();
    ordy_s[1] = 1'b0;
    drive(1, 1'b1);
    drive(1, 1'b1);
    vld_s[1] = 1'b0;
    check("t2_held", 32'(out_valid_s[1]), 32'h1);
    sync_s[1] = 1'b1;
    cyc();
    sync_s[1] = 1'b0;
    check("t2_sync_drop", 32'(out_valid_s[1]), 32'h0);
    check("t2_out_kept", 32'(out_b), 32'h3);
    check("t2_ovf", 32'(ovf_s[1]), 32'h0);
    ordy_s[1] = 1'b1;
    cyc();

    // Continuous streaming, NBITS=4, skid path exercised between words
    q2.push_back(4'b1101);
    q2.push_back(4'b0100);
    for (int i = 0; i < 8; i++) drive(2, b4[i][0]);
    vld_s[2] = 1'b0;
    cyc();
    check("t4_ovf", 32'(ovf_s[2]), 32'h0);
    check("t4_last", 32'(out_c), 32'h4);

    // Asynchronous reset while holding a word
    ordy_s[0] = 1'b0;
    drive(0, 1'b1);
    drive(0, 1'b1);
    vld_s[0] = 1'b0;
    check("t6_pre_valid", 32'(out_valid_s[0]), 32'h1);
    check("t6_pre_out", 32'(out_a), 32'h3);
    #1 rst = 1'b1;
    #1;
    check("t6_valid", 32'(out_valid_s[0]), 32'h0);
    check("t6_out", 32'(out_a), 32'h0);
    check("t6_in_ready", 32'(in_ready_s[0]), 32'h1);
    check("t6_ovf", 32'(ovf_s[0]), 32'h0);
    #4 rst = 1'b0;
    ordy_s[0] = 1'b1;
    cyc();
    q0.push_back(4'b0010);
    drive(0, 1'b0);
    drive(0, 1'b1);
    vld_s[0] = 1'b0;
    cyc(2);

    check("sb_a_drained", 32'(q0.size()), 32'h0);
    check("sb_b_drained", 32'(q1.size()), 32'h0);
    check("sb_c_drained", 32'(q2.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cv_bus_drive.md
Name: cv_bus_drive

Overview:
Driving end of the cv bus interface. Collects a single-bit serial stream into an NBITS-wide parallel word and presents it on `out` with a valid/ready handshake to the bus-terminating consumer (e.g. cv_bus_term).
- Acts as the deserializer/producer for the bus that cv_bus_term-style cells consume.
- Sits between a serial source and any bus-input schematic cell in the TEST hierarchy.

Parameters:
NBITS, 2, width of the parallel output bus; legal range 2..16.
MSB_FIRST, 0, 0 = first serial bit lands in out[0]; 1 = first serial bit lands in out[NBITS-1].

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
VDD  input  1  supply pin, kept for netlist compatibility; no logic function.
VSS  input  1  ground pin, kept for netlist compatibility; no logic function.
sync  input  1  frame resync; discards any partial word.
in  input  1  serial data bit.
in_valid  input  1  `in` is valid this cycle.
in_ready  output  1  block accepts `in` this cycle.
out  output  NBITS  assembled parallel word.
out_valid  output  1  `out` holds a complete word.
out_ready  input  1  consumer accepts `out` this cycle.
ovf  output  1  sticky flag: a serial bit was offered while the block could not accept it.

Behaviour:
- Reset (async assert, sync-released use of clk): state=FILL, bit count=0, shift register=0, out=0, out_valid=0, in_ready=1, ovf=0.
- State machine: FILL and HOLD.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid, the bit is written at index cnt (MSB_FIRST=0) or NBITS-1-cnt (MSB_FIRST=1), and cnt increments.
  - When the NBITS-th bit is accepted: copy the shift register to `out`, cnt=0, go to HOLD. out_valid rises the cycle after the last bit is accepted (latency 1 clock).
- HOLD:
  - out_valid=1 and `out` is stable.
  - in_ready equals out_ready (one-bit skid). If out_ready and in_valid occur together, the word is consumed, the new bit is stored at position 0 of the next word with cnt=1, and the state goes to FILL.
  - out_ready without in_valid: go to FILL with cnt=0.
  - in_valid with out_ready=0: the bit is dropped and ovf is set.
- sync:
  - Highest priority among synchronous events. Sets cnt=0, clears the shift register, and forces FILL.
  - If in HOLD with out_ready=1 on the same cycle, the word is still consumed. If out_ready=0, the word is discarded and out_valid drops the next cycle.
  - A bit offered on the sync cycle is ignored and does not set ovf.
- `out` holds its last value after consumption until the next word completes; only out_valid qualifies it.
- cnt width is clog2(NBITS+1). Wrap occurs only at exactly NBITS; no modulo aliasing.
- ovf clears only on rst.
- Reset asserted mid-word or mid-HOLD: immediate return to reset values; no partial word is emitted.

Decomposition:
- Shared package cv_bus_pkg:
  - state enum {FILL, HOLD}
  - function clog2
  - constant CV_BUS_MAX_NBITS=16
- No sub-module required. Optional: cv_bus_shreg (parameterised indexed-write register with clear) if reuse with a future serializer is planned.

Test Plan:
1. NBITS=2, MSB_FIRST=0, out_ready=1; bits 1,0 on consecutive cycles -> out=2'b01, out_valid high one cycle after the second bit, one-cycle pulse.
2. NBITS=2, MSB_FIRST=1; bits 1,0 -> out=2'b10; repeat with 0,1 -> 2'b01.
3. Backpressure: word complete with out_ready=0 for 3 cycles while in_valid=1 -> out stable, in_ready=0, ovf=1; out_ready=1 plus bit 1 -> word consumed, next word begins with cnt=1.
4. Continuous streaming, NBITS=4, out_ready=1, bits 1,0,1,1,0,0,1,0 -> words 4'b1101 then 4'b0100, no dropped bits, ovf=0.
5. Resync: after one bit of a 2-bit word, pulse sync with in_valid=1 (bit 1) -> that bit ignored, then 0,1 -> out=2'b10, ovf=0.
6. Async reset mid-HOLD (out_valid=1, out=2'b11) -> out_valid=0, out=0, in_ready=1 with no clock edge; after release, normal fill resumes.
